// File: rtl/hc595_pkg.sv
// Shared state encoding and frame-width helper for the 74HC595 cascade driver.
package hc595_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShiftLo,
      StShiftHi,
      StLatch
   } state_e;

   localparam int unsigned BITS_PER_CHIP = 8;

   function automatic int unsigned frame_width(input int unsigned n_chips);
      return BITS_PER_CHIP * n_chips;
   endfunction

endpackage

// File: rtl/hc595_phase_timer.sv
// Counts CLK_DIV cycles per FSM phase and ticks on the last cycle of each phase.
module hc595_phase_timer #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_run,
   input  logic i_clear,
   output logic o_tick
);

   localparam int unsigned CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n || i_clear || !i_run) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = i_run && (r_cnt == LAST);

endmodule

// File: rtl/hc595_chain_driver.sv
// Serialises a parallel frame into a cascade of 74HC595s with SRCLK/RCLK/OE_n generation.
module hc595_chain_driver
   import hc595_pkg::*;
#(
   parameter int unsigned N_CHIPS   = 2,
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic [8*N_CHIPS-1:0]       i_data,
   input  logic                       i_data_valid,
   output logic                       o_data_ready,
   output logic                       o_dio,
   output logic                       o_srclk,
   output logic                       o_rclk,
   output logic                       o_oe_n,
   output logic                       o_frame_done
);

   localparam int unsigned W   = frame_width(N_CHIPS);
   localparam int unsigned BCW = $clog2(W) + 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

   function automatic logic first_bit(input logic [W-1:0] v);
      return (MSB_FIRST != 0) ? v[W-1] : v[0];
   endfunction

   function automatic logic [W-1:0] shift_out(input logic [W-1:0] v);
      return (MSB_FIRST != 0) ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
   endfunction

   state_e           r_state;
   logic [W-1:0]     r_shift;
   logic [BCW-1:0]   r_bit_cnt;
   logic             r_dio;
   logic             r_srclk;
   logic             r_rclk;
   logic             r_oe_n;
   logic             r_frame_done;
   logic             r_ready;

   logic w_tick;
   logic w_run;
   logic w_state_change;

   assign w_run          = (r_state != StIdle);
   // Every tick ends a phase and moves the FSM, so it doubles as the timer clear.
   assign w_state_change = (r_state == StIdle) ? i_data_valid : w_tick;

   hc595_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_run     (w_run),
      .i_clear   (w_state_change),
      .o_tick    (w_tick)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_dio        <= 1'b0;
         r_srclk      <= 1'b0;
         r_rclk       <= 1'b0;
         r_oe_n       <= 1'b1;
         r_frame_done <= 1'b0;
         r_ready      <= 1'b1;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_data_valid) begin
                  r_state   <= StShiftLo;
                  r_ready   <= 1'b0;
                  r_shift   <= shift_out(i_data);
                  r_dio     <= first_bit(i_data);
                  r_bit_cnt <= '0;
                  r_srclk   <= 1'b0;
               end
            end
            StShiftLo: begin
               if (w_tick) begin
                  r_state <= StShiftHi;
                  r_srclk <= 1'b1;
               end
            end
            StShiftHi: begin
               if (w_tick) begin
                  r_srclk <= 1'b0;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state <= StLatch;
                     r_rclk  <= 1'b1;
                     r_dio   <= 1'b0;
                  end else begin
                     r_state   <= StShiftLo;
                     r_dio     <= first_bit(r_shift);
                     r_shift   <= shift_out(r_shift);
                     r_bit_cnt <= r_bit_cnt + BCW'(1);
                  end
               end
            end
            StLatch: begin
               if (w_tick) begin
                  r_state      <= StIdle;
                  r_rclk       <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_oe_n       <= 1'b0;
                  r_ready      <= 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_data_ready = r_ready;
   assign o_dio        = r_dio;
   assign o_srclk      = r_srclk;
   assign o_rclk       = r_rclk;
   assign o_oe_n       = r_oe_n;
   assign o_frame_done = r_frame_done;

endmodule
